// File: rtl/register_file_2r1w_pkg.sv
// Shared widths and the hardwired-zero index for the register file, decoder and read path.
package register_file_2r1w_pkg;

    localparam int unsigned REG_DATA_W   = 32;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned REG_ZERO_IDX = 0;

endpackage

// File: rtl/register_file_2r1w_decoder_1to32.sv
// Write-port address decoder: one-hot enable per register, all zeros when disabled.
module decoder_1to32
    import register_file_2r1w_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic                 enable_i,
    input  logic [ADDR_W-1:0]    addr_i,
    output logic [2**ADDR_W-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (enable_i) begin
            onehot_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// 2-read / 1-write register file: synchronous write, combinational reads, optional
// hardwired zero register and optional same-cycle write-to-read bypass.
module register_file_2r1w
    import register_file_2r1w_pkg::*;
#(
    parameter int unsigned DATA_W   = REG_DATA_W,
    parameter int unsigned ADDR_W   = REG_ADDR_W,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO_IDX);

    logic [DEPTH-1:0]  we_vec;
    logic [DATA_W-1:0] reg_rd [DEPTH];
    logic              hit1;
    logic              hit2;

    decoder_1to32 #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .enable_i (we),
        .addr_i   (wr_addr),
        .onehot_o (we_vec)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        localparam bit HARDWIRED = (ZERO_REG != 0) && (i == REG_ZERO_IDX);

        logic              en;
        logic [DATA_W-1:0] data_q;
        logic [DATA_W-1:0] data_d;

        // The hardwired slot never loads, so it stays at its reset value and folds to a constant.
        assign en     = we_vec[i] && !HARDWIRED;
        assign data_d = en ? wr_data : data_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign reg_rd[i] = data_q;
    end

    // Forwarding is held off during reset so every read is zero while it is asserted.
    assign hit1 = (BYPASS != 0) && we && !reset && (rd_addr1 == wr_addr)
                  && !((ZERO_REG != 0) && (rd_addr1 == ZERO_ADDR));
    assign hit2 = (BYPASS != 0) && we && !reset && (rd_addr2 == wr_addr)
                  && !((ZERO_REG != 0) && (rd_addr2 == ZERO_ADDR));

    always_comb begin
        rd_data1 = reg_rd[rd_addr1];
        rd_data2 = reg_rd[rd_addr2];
        if (hit1) begin
            rd_data1 = wr_data;
        end
        if (hit2) begin
            rd_data2 = wr_data;
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed plus random checks of the register file against an array model, for both
// the default build and a bypass-enabled build driven by the same inputs.
module tb_register_file_2r1w;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [31:0] bp_data1;
    logic [31:0] bp_data2;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    register_file_2r1w dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    register_file_2r1w #(
        .BYPASS (1)
    ) dut_bp (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (bp_data1),
        .rd_data2 (bp_data2)
    );

    // Architectural view: reset reads zero, bypass forwards a live write, else stored value.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit bp);
        if (reset) return 32'h0;
        if (bp && we && a == wr_addr && a != 5'd0) return wr_data;
        if (a == 5'd0) return 32'h0;
        return model[a];
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reads(input string tag);
        cmp({tag, "_p1"},    rd_data1, exp_rd(rd_addr1, 1'b0));
        cmp({tag, "_p2"},    rd_data2, exp_rd(rd_addr2, 1'b0));
        cmp({tag, "_bp_p1"}, bp_data1, exp_rd(rd_addr1, 1'b1));
        cmp({tag, "_bp_p2"}, bp_data2, exp_rd(rd_addr2, 1'b1));
    endtask

    // Called just after a falling edge; checks before and after the next rising edge.
    task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2, input string tag);
        we       = w;
        wr_addr  = wa;
        wr_data  = wd;
        rd_addr1 = a1;
        rd_addr2 = a2;
        #1 check_reads({tag, "_pre"});
        @(posedge clk);
        if (!reset && we && wr_addr != 5'd0) model[wr_addr] = wr_data;
        #1 check_reads({tag, "_post"});
        @(negedge clk);
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
        we = 1'b0; wr_addr = '0; wr_data = '0; rd_addr1 = '0; rd_addr2 = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        rd_addr1 = 5'd1; rd_addr2 = 5'd31;
        #1 check_reads("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // Asynchronous reset clears loaded registers with no clock edge.
        step(1'b1, 5'd3,  32'h1111_2222, 5'd3,  5'd10, "load3");
        step(1'b1, 5'd10, 32'h3333_4444, 5'd3,  5'd10, "load10");
        step(1'b1, 5'd20, 32'h5555_6666, 5'd20, 5'd10, "load20");
        we = 1'b0;
        #2 assert_reset();
        rd_addr1 = 5'd3; rd_addr2 = 5'd10;
        #1 check_reads("async_rst_a");
        rd_addr1 = 5'd20; rd_addr2 = 5'd0;
        #1 check_reads("async_rst_b");
        @(negedge clk);
        reset = 1'b0;

        // Write/read walk.
        for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'h0000_1000 + 32'(i), 5'd0, 5'd0, "walk_wr");
        for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 32'h0, 5'(i), 5'(i), "walk_rd");
        rd_addr1 = 5'd17;
        #1 cmp("walk_reg17_const", rd_data1, 32'h0000_1011);

        step(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, "zero_reg");
        cmp("zero_reg_const", bp_data1, 32'h0);

        step(1'b0, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5, "we_off");
        cmp("we_off_reg5_const", rd_data1, 32'h0000_1005);

        // Same-cycle read of the write target.
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFE_F00D; rd_addr1 = 5'd7; rd_addr2 = 5'd7;
        #1 cmp("same_cyc_nobp_pre", rd_data1, 32'h0000_1007);
        cmp("same_cyc_bp_pre", bp_data2, 32'hCAFE_F00D);
        step(1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd7, "same_cyc");
        cmp("same_cyc_nobp_post", rd_data2, 32'hCAFE_F00D);

        // Reset held across a write edge loses the write; next write lands after release.
        assert_reset();
        step(1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd7, "rst_during_wr");
        reset = 1'b0;
        cmp("rst_during_wr_reg9", rd_data1, 32'h0);
        step(1'b1, 5'd9, 32'h9999_AAAA, 5'd9, 5'd9, "wr_after_rst");
        cmp("wr_after_rst_reg9", rd_data1, 32'h9999_AAAA);

        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                 5'($urandom), 5'($urandom), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
